rc4_ksa: RTL

//  RC4 key-scheduling stage. On request, fills S memory with identity (S[i]=i), then runs the
//  KSA swap loop over the secret key, leaving the permuted state array in S.

---
 rtl/rc4_ksa.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage: fills the shared S RAM with the identity permutation,
// then runs the KSA swap loop over the latched key. Idle/busy is signalled on rdy.
module rc4_ksa #(
  parameter int KEYLEN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  input  logic [8*KEYLEN-1:0]   key,
  output logic [7:0]            s_addr,
  input  logic [7:0]            s_rddata,
  output logic [7:0]            s_wrdata,
  output logic                  s_wren,
  output logic [3:0]            dbg_state
);

  localparam int KW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    RDI1  = 4'd2,
    RDI2  = 4'd3,
    CALCJ = 4'd4,
    RDJ1  = 4'd5,
    RDJ2  = 4'd6,
    WRI   = 4'd7,
    WRJ   = 4'd8,
    NEXT  = 4'd9
  } state_t;

  // Handshake: a run starts on any rising edge where en && rdy; key is captured on
  // that same edge. While busy (rdy=0) both en and key are ignored.

  state_t              state_q, state_d;
  logic [7:0]          i_q, i_d;
  logic [7:0]          j_q, j_d;
  logic [KW-1:0]       kidx_q, kidx_d;
  logic [7:0]          si_q, si_d;
  logic [7:0]          sj_q, sj_d;
  logic [8*KEYLEN-1:0] key_q, key_d;
  logic [7:0]          key_byte;

  // Key byte 0 is the most significant byte of the key.
  always_comb begin
    key_byte = 8'd0;
    for (int n = 0; n < KEYLEN; n++) begin
      if (kidx_q == n[KW-1:0]) key_byte = key_q[8*(KEYLEN-1-n) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = INIT;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = '0;
          key_d   = key;
        end
      end
      INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = RDI1;
      end
      RDI1:  state_d = RDI2;
      RDI2: begin
        si_d    = s_rddata;
        state_d = CALCJ;
      end
      CALCJ: begin
        j_d     = j_q + si_q + key_byte;
        state_d = RDJ1;
      end
      RDJ1:  state_d = RDJ2;
      RDJ2: begin
        sj_d    = s_rddata;
        state_d = WRI;
      end
      WRI:   state_d = WRJ;
      WRJ:   state_d = NEXT;
      NEXT: begin
        // kidx tracks i mod KEYLEN without a divider.
        kidx_d = (kidx_q == KW'(KEYLEN-1)) ? '0 : kidx_q + KW'(1);
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = RDI1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      kidx_q  <= '0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  // RAM port is decoded straight from state so reset clears it immediately.
  always_comb begin
    rdy      = (state_q == IDLE);
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (state_q)
      INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
      end
      RDI1, RDI2: s_addr = i_q;
      RDJ1, RDJ2: s_addr = j_q;
      WRI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
      end
      WRJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule
